alu_flags_unit: RTL and testbench

Flag register and branch-condition evaluator sitting directly downstream of the ALU compare block. It consumes the compare block's above/below outputs, holds the carry and zero flags, and answers condition queries from the branch/issue logic through a valid/ready channel with a 2-entry output FIFO. Query results carry the flag state in effect at acceptance, including a same-cycle flag write.

---
 rtl/alu_flags_unit.sv | 128 ++++++++++++
 tb/tb_alu_flags_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flags_unit.sv
// alu_flags_unit: carry/zero flag register fed by the ALU compare block, plus
// a branch-condition evaluator that answers queries through a valid/ready
// channel backed by a 2-entry in-order result FIFO. Queries see the flag
// values that will be registered at the same edge, so a same-cycle flag write
// is visible to the query.
module alu_flags_unit #(
  parameter int WORD_WIDTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       fw_valid_i,
  input  logic [1:0] op_i,
  input  logic       above_i,
  input  logic       below_i,
  input  logic       q_valid_i,
  input  logic [2:0] q_cond_i,
  output logic       q_ready_o,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic       res_taken_o,
  output logic [1:0] res_flags_o,
  output logic       cf_o,
  output logic       zf_o
);

  // The compared words never enter this block; the width only has to make sense.
  if (WORD_WIDTH < 1) begin : g_width_check
    $error("alu_flags_unit: WORD_WIDTH must be at least 1");
  end

  // FIFO entry layout: [2] taken, [1] ZF, [0] CF
  logic       cf_reg;
  logic       zf_reg;
  logic       cf_next;
  logic       zf_next;
  logic       taken_next;
  logic [1:0] count_reg;
  logic [2:0] slot_reg [2];
  logic [2:0] push_entry;
  logic       push;
  logic       pop;

  // Next flag values; above & below together (illegal) falls out as CF=1, ZF=0.
  always_comb begin
    cf_next = cf_reg;
    zf_next = zf_reg;
    if (fw_valid_i && op_i[0]) begin
      cf_next = below_i;
    end
    if (fw_valid_i && op_i[1]) begin
      zf_next = ~(above_i | below_i);
    end
  end

  // Condition evaluation on the bypassed (next) flag values.
  always_comb begin
    taken_next = 1'b0;
    case (q_cond_i)
      3'b000:  taken_next = 1'b1;
      3'b001:  taken_next = zf_next;
      3'b010:  taken_next = ~zf_next;
      3'b011:  taken_next = cf_next;
      3'b100:  taken_next = ~cf_next;
      3'b101:  taken_next = ~cf_next & ~zf_next;
      3'b110:  taken_next = cf_next | zf_next;
      default: taken_next = 1'b0;
    endcase
  end

  // Ready depends on state only, so a pop while full frees a slot next cycle.
  assign q_ready_o   = ~rst_i & (count_reg != 2'd2);
  assign push        = q_valid_i & q_ready_o;
  assign res_valid_o = (count_reg != 2'd0);
  assign pop         = res_valid_o & res_ready_i;
  assign push_entry  = {taken_next, zf_next, cf_next};

  assign res_taken_o = res_valid_o & slot_reg[0][2];
  assign res_flags_o = res_valid_o ? slot_reg[0][1:0] : 2'b00;
  assign cf_o        = cf_reg;
  assign zf_o        = zf_reg;

  // Flag register: updated every cycle from the next-value logic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cf_reg <= 1'b0;
      zf_reg <= 1'b0;
    end else begin
      cf_reg <= cf_next;
      zf_reg <= zf_next;
    end
  end

  // Result FIFO: slot 0 is always the head; entries shift down on pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_reg   <= 2'd0;
      slot_reg[0] <= 3'b000;
      slot_reg[1] <= 3'b000;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) begin
            slot_reg[0] <= push_entry;
          end else begin
            slot_reg[1] <= push_entry;
          end
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          slot_reg[0] <= slot_reg[1];
          count_reg   <= count_reg - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new entry lands behind whatever remains.
          if (count_reg == 2'd1) begin
            slot_reg[0] <= push_entry;
          end else begin
            slot_reg[0] <= slot_reg[1];
            slot_reg[1] <= push_entry;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flags_unit.sv
// Self-checking bench for alu_flags_unit: a reference model of the flags and a
// scoreboard queue of expected results, checked on every falling edge.
module tb_alu_flags_unit;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       fw_valid_i;
  logic [1:0] op_i;
  logic       above_i;
  logic       below_i;
  logic       q_valid_i;
  logic [2:0] q_cond_i;
  logic       q_ready_o;
  logic       res_valid_o;
  logic       res_ready_i;
  logic       res_taken_o;
  logic [1:0] res_flags_o;
  logic       cf_o;
  logic       zf_o;

  int total = 0;
  int bad   = 0;

  logic [2:0] sb[$];    // expected {taken, ZF, CF}
  logic       m_cf;
  logic       m_zf;

  alu_flags_unit #(.WORD_WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fw_valid_i  (fw_valid_i),
    .op_i        (op_i),
    .above_i     (above_i),
    .below_i     (below_i),
    .q_valid_i   (q_valid_i),
    .q_cond_i    (q_cond_i),
    .q_ready_o   (q_ready_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_taken_o (res_taken_o),
    .res_flags_o (res_flags_o),
    .cf_o        (cf_o),
    .zf_o        (zf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_true(input logic [2:0] c, input logic cf, input logic zf);
    case (c)
      3'd0: return 1'b1;
      3'd1: return zf;
      3'd2: return !zf;
      3'd3: return cf;
      3'd4: return !cf;
      3'd5: return !cf && !zf;
      3'd6: return cf || zf;
      default: return 1'b0;
    endcase
  endfunction

  // One clock cycle: inputs are already driven; check outputs at the falling
  // edge against the model, advance the model, then move past the rising edge.
  task automatic cycle(output bit acc);
    logic exp_ready;
    logic ncf;
    logic nzf;
    logic [2:0] head;
    @(negedge clk_i);
    exp_ready = !rst_i && (sb.size() != 2);
    check_val("q_ready", {7'd0, q_ready_o}, {7'd0, exp_ready});
    check_val("res_valid", {7'd0, res_valid_o}, {7'd0, sb.size() != 0});
    head = (sb.size() != 0) ? sb[0] : 3'b000;
    check_val("res_taken", {7'd0, res_taken_o}, {7'd0, head[2]});
    check_val("res_flags", {6'd0, res_flags_o}, {6'd0, head[1:0]});
    check_val("cf", {7'd0, cf_o}, {7'd0, m_cf});
    check_val("zf", {7'd0, zf_o}, {7'd0, m_zf});
    acc = 1'b0;
    if (rst_i) begin
      sb.delete();
      m_cf = 1'b0;
      m_zf = 1'b0;
    end else begin
      ncf = (fw_valid_i && op_i[0]) ? below_i : m_cf;
      nzf = (fw_valid_i && op_i[1]) ? !(above_i || below_i) : m_zf;
      acc = q_valid_i && exp_ready;
      if (sb.size() != 0 && res_ready_i) begin
        $display("result taken=%0b flags=%02b", res_taken_o, res_flags_o);
        void'(sb.pop_front());
      end
      if (acc) begin
        sb.push_back({cond_true(q_cond_i, ncf, nzf), nzf, ncf});
      end
      m_cf = ncf;
      m_zf = nzf;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    fw_valid_i = 0; op_i = 0; above_i = 0; below_i = 0;
    q_valid_i = 0; q_cond_i = 0;
  endtask

  task automatic flag_write(input logic [1:0] op, input logic a, input logic b);
    fw_valid_i = 1; op_i = op; above_i = a; below_i = b;
  endtask

  // Hold a query until accepted, within a bounded number of cycles.
  task automatic query(input logic [2:0] c, input int limit);
    bit acc;
    int n;
    q_valid_i = 1; q_cond_i = c;
    n = 0;
    acc = 0;
    while (!acc && n < limit) begin
      cycle(acc);
      n++;
      fw_valid_i = 0;
    end
    if (!acc) check_val("query_timeout", 8'd0, 8'd1);
    q_valid_i = 0;
  endtask

  initial begin
    bit acc;
    idle_inputs();
    res_ready_i = 0;
    m_cf = 0; m_zf = 0;
    rst_i = 1;
    @(posedge clk_i); #1;
    cycle(acc); cycle(acc);               // in reset: ready low, flags 0
    rst_i = 0;
    cycle(acc);                           // ready high one cycle after release

    // Flag write then LTU query
    res_ready_i = 1;
    flag_write(2'b11, 0, 1);
    cycle(acc);
    idle_inputs();
    check_val("tp_cf_after_write", {7'd0, cf_o}, 8'd1);
    query(3'd3, 4);
    check_val("tp_ltu_taken", {7'd0, res_taken_o}, 8'd1);
    check_val("tp_ltu_flags", {6'd0, res_flags_o}, 8'b01);
    cycle(acc);

    // Same-cycle bypass: clear CF, then set ZF together with an EQ query
    flag_write(2'b01, 0, 0);
    cycle(acc);
    flag_write(2'b10, 0, 0);
    query(3'd1, 4);
    check_val("tp_bypass_taken", {7'd0, res_taken_o}, 8'd1);
    check_val("tp_bypass_flags", {6'd0, res_flags_o}, 8'b10);
    query(3'd2, 4);
    check_val("tp_ne_taken", {7'd0, res_taken_o}, 8'd0);
    cycle(acc);

    // Backpressure: 000, 111, 000 with consumer stalled
    res_ready_i = 0;
    query(3'd0, 4);
    query(3'd7, 4);
    q_valid_i = 1; q_cond_i = 3'd0;
    cycle(acc); check_val("tp_third_held", {7'd0, acc}, 8'd0);
    cycle(acc); check_val("tp_third_held2", {7'd0, acc}, 8'd0);
    res_ready_i = 1;
    cycle(acc);                           // pop head, still full this cycle
    check_val("tp_third_after_pop", {7'd0, acc}, 8'd0);
    res_ready_i = 0;
    query(3'd0, 4);
    res_ready_i = 1;
    cycle(acc); cycle(acc); cycle(acc);

    // Push/pop at count 1 with CF=0, ZF=0 and GTU
    flag_write(2'b11, 1, 0);
    res_ready_i = 0;
    query(3'd0, 4);                       // count becomes 1
    res_ready_i = 1;
    query(3'd5, 4);                       // simultaneous push and pop
    check_val("tp_gtu_head", {7'd0, res_taken_o}, 8'd1);
    check_val("tp_gtu_valid", {7'd0, res_valid_o}, 8'd1);
    cycle(acc);

    // Illegal above & below: CF=1, ZF=0
    flag_write(2'b11, 1, 1);
    cycle(acc);
    idle_inputs();
    check_val("illegal_cf", {7'd0, cf_o}, 8'd1);
    check_val("illegal_zf", {7'd0, zf_o}, 8'd0);

    // Reset mid-operation with two results pending and CF=1
    res_ready_i = 0;
    query(3'd0, 4);
    query(3'd3, 4);
    rst_i = 1;
    flag_write(2'b11, 0, 0);
    q_valid_i = 1;
    cycle(acc);
    rst_i = 0;
    idle_inputs();
    check_val("rst_mid_valid", {7'd0, res_valid_o}, 8'd0);
    check_val("rst_mid_cf", {7'd0, cf_o}, 8'd0);
    res_ready_i = 1;
    cycle(acc); cycle(acc);

    // Random traffic checked against the model
    for (int i = 0; i < 300; i++) begin
      rst_i       = ($urandom_range(0, 59) == 0);
      fw_valid_i  = $urandom_range(0, 1);
      op_i        = 2'($urandom_range(0, 3));
      above_i     = $urandom_range(0, 1);
      below_i     = $urandom_range(0, 1);
      q_valid_i   = $urandom_range(0, 1);
      q_cond_i    = 3'($urandom_range(0, 7));
      res_ready_i = ($urandom_range(0, 2) != 0);
      cycle(acc);
    end
    rst_i = 0;
    idle_inputs();
    res_ready_i = 1;
    cycle(acc); cycle(acc); cycle(acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
